// File: rtl/display_scan_ctrl_if.sv
// Write port of the display scan controller: valid/ready handshake carrying the
// 32-bit value shown on the eight seven-segment digits.
interface display_scan_ctrl_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 8-digit seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module display_scan_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    display_scan_ctrl_if.slave        wr,
    output logic [2:0]                num,
    output logic [31:0]               dig,
    output logic [7:0]                an,
    output logic                      frame_done
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc;
    logic          pend_valid;
    logic [31:0]   pend_data;
    logic          tick;
    logic          wrap;
    logic          accept;
    logic          commit;
    logic [2:0]    num_next;
    logic [7:0]    an_next;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above 0 stays dark when it and every higher scanned nibble are zero.
    function automatic logic [7:0] an_decode(input logic [2:0] idx, input logic [31:0] val);
        logic [7:0] r;
        logic       upper;
        r     = '1;
        upper = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < NUM_DIGITS && int'(idx) == k) r[k] = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            if (j < NUM_DIGITS && j >= int'(idx)) upper = upper | (|val[4*j +: 4]);
        end
        if (idx != 3'd0 && !upper) r = '1;
        return r;
    endfunction
`else
    function automatic logic [7:0] an_decode(input logic [2:0] idx);
        logic [7:0] r;
        r = '1;
        for (int k = 0; k < 8; k++) begin
            if (k < NUM_DIGITS && int'(idx) == k) r[k] = 1'b0;
        end
        return r;
    endfunction
`endif

    always_comb begin
        tick     = en && (presc == PW'(SCAN_DIV - 1));
        wrap     = tick && (num == 3'(NUM_DIGITS - 1));
        num_next = num;
        if (tick) num_next = wrap ? 3'd0 : num + 3'd1;
        accept   = wr.wr_valid && !pend_valid;
        commit   = pend_valid && (wrap || !en);
`ifdef LEADING_ZERO_BLANK_EN
        // Decode against the value that will be visible next cycle so a commit never flashes.
        an_next  = an_decode(num_next, commit ? pend_data : dig);
`else
        an_next  = an_decode(num_next);
`endif
    end

    assign wr.wr_ready = ~pend_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            num        <= 3'd0;
            an         <= 8'hFF;
            frame_done <= 1'b0;
            dig        <= 32'h0;
            pend_valid <= 1'b0;
            pend_data  <= 32'h0;
        end else begin
            if (!en) begin
                presc      <= '0;
                num        <= 3'd0;
                an         <= 8'hFF;
                frame_done <= 1'b0;
            end else begin
                presc      <= tick ? '0 : presc + PW'(1);
                num        <= num_next;
                an         <= an_next;
                frame_done <= wrap;
            end
            // Commit and accept are exclusive: accept needs an empty buffer, commit a full one.
            if (commit) begin
                dig        <= pend_data;
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_data  <= wr.wr_data;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (SCAN_DIV=4; 8- and 4-digit instances).
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  num1, num2;
    logic [31:0] dig1, dig2;
    logic [7:0]  an1, an2;
    logic        fd1, fd2;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    display_scan_ctrl_if bus1 ();
    display_scan_ctrl_if bus2 ();

    display_scan_ctrl #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(bus1),
        .num(num1), .dig(dig1), .an(an1), .frame_done(fd1)
    );

    display_scan_ctrl #(.SCAN_DIV(4), .NUM_DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(bus2),
        .num(num2), .dig(dig2), .an(an2), .frame_done(fd2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got hung run, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After this, en is high and the next step lands just after scan edge 1.
    task automatic start_scan();
        en = 1'b0;
        step();
        en = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        bus1.wr_valid = 1'b0; bus1.wr_data = 32'h0;
        bus2.wr_valid = 1'b0; bus2.wr_data = 32'h0;
        #12;
        tests++; if (an1 !== 8'hFF) begin fails++; $display("FAIL reset_an: got %h expected ff", an1); end
        tests++; if (num1 !== 3'd0) begin fails++; $display("FAIL reset_num: got %0d expected 0", num1); end
        tests++; if (dig1 !== 32'h0) begin fails++; $display("FAIL reset_dig: got %h expected 0", dig1); end
        tests++; if (bus1.wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus1.wr_ready); end
        tests++; if (fd1 !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b expected 0", fd1); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        tests++; if (an1 !== 8'hFF) begin fails++; $display("FAIL idle_an: got %h expected ff", an1); end
        tests++; if (num1 !== 3'd0) begin fails++; $display("FAIL idle_num: got %0d expected 0", num1); end
    endtask

    task automatic test_scan();
        logic [2:0] en_num;
        logic [7:0] e_an;
        start_scan();
        for (int i = 0; i < 40; i++) begin
            step();
            en_num = 3'((cyc / 4) % 8);
            e_an   = ~(8'b1 << en_num);
            tests++; if (num1 !== en_num) begin fails++; $display("FAIL scan_num c%0d: got %0d expected %0d", cyc, num1, en_num); end
            tests++; if (an1 !== e_an) begin fails++; $display("FAIL scan_an c%0d: got %h expected %h", cyc, an1, e_an); end
            tests++; if (fd1 !== (cyc == 32)) begin fails++; $display("FAIL scan_fd c%0d: got %b expected %b", cyc, fd1, cyc == 32); end
        end
    endtask

    task automatic test_write();
        start_scan();
        while (cyc < 12) step();
        tests++; if (num1 !== 3'd3) begin fails++; $display("FAIL wr_slot: got %0d expected 3", num1); end
        bus1.wr_valid = 1'b1; bus1.wr_data = 32'h1234_5678;
        step();
        bus1.wr_valid = 1'b0;
        tests++; if (bus1.wr_ready !== 1'b0) begin fails++; $display("FAIL wr_busy: got %b expected 0", bus1.wr_ready); end
        tests++; if (dig1 !== 32'h0) begin fails++; $display("FAIL wr_hold0: got %h expected 0", dig1); end
        while (cyc < 31) step();
        tests++; if (dig1 !== 32'h0) begin fails++; $display("FAIL wr_hold31: got %h expected 0", dig1); end
        step();
        tests++; if (dig1 !== 32'h1234_5678) begin fails++; $display("FAIL wr_commit: got %h expected 12345678", dig1); end
        tests++; if (bus1.wr_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_back: got %b expected 1", bus1.wr_ready); end
        tests++; if (fd1 !== 1'b1) begin fails++; $display("FAIL wr_fd: got %b expected 1", fd1); end
    endtask

    task automatic test_back_to_back();
        start_scan();
        step();
        bus1.wr_valid = 1'b1; bus1.wr_data = 32'hAAAA_0001;
        step();
        tests++; if (bus1.wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %b expected 0", bus1.wr_ready); end
        bus1.wr_data = 32'hBBBB_0002;
        while (cyc < 20) step();
        tests++; if (bus1.wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_held: got %b expected 0", bus1.wr_ready); end
        tests++; if (dig1 !== 32'h1234_5678) begin fails++; $display("FAIL b2b_old: got %h expected 12345678", dig1); end
        while (cyc < 32) step();
        tests++; if (dig1 !== 32'hAAAA_0001) begin fails++; $display("FAIL b2b_first: got %h expected aaaa0001", dig1); end
        tests++; if (bus1.wr_ready !== 1'b1) begin fails++; $display("FAIL b2b_free: got %b expected 1", bus1.wr_ready); end
        step();
        bus1.wr_valid = 1'b0;
        tests++; if (bus1.wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_second_acc: got %b expected 0", bus1.wr_ready); end
        while (cyc < 63) step();
        tests++; if (dig1 !== 32'hAAAA_0001) begin fails++; $display("FAIL b2b_wait: got %h expected aaaa0001", dig1); end
        step();
        tests++; if (dig1 !== 32'hBBBB_0002) begin fails++; $display("FAIL b2b_second: got %h expected bbbb0002", dig1); end
    endtask

    task automatic test_en_drop_reset();
        start_scan();
        step();
        bus1.wr_valid = 1'b1; bus1.wr_data = 32'hCAFE_F00D;
        step();
        bus1.wr_valid = 1'b0;
        while (cyc < 10) step();
        en = 1'b0;
        step();
        tests++; if (dig1 !== 32'hCAFE_F00D) begin fails++; $display("FAIL endrop_dig: got %h expected cafef00d", dig1); end
        tests++; if (an1 !== 8'hFF) begin fails++; $display("FAIL endrop_an: got %h expected ff", an1); end
        tests++; if (num1 !== 3'd0) begin fails++; $display("FAIL endrop_num: got %0d expected 0", num1); end
        tests++; if (bus1.wr_ready !== 1'b1) begin fails++; $display("FAIL endrop_ready: got %b expected 1", bus1.wr_ready); end
        start_scan();
        while (cyc < 13) step();
        bus1.wr_valid = 1'b1; bus1.wr_data = 32'hDEAD_BEEF;
        step();
        bus1.wr_valid = 1'b0;
        tests++; if (bus1.wr_ready !== 1'b0) begin fails++; $display("FAIL rst_pend: got %b expected 0", bus1.wr_ready); end
        while (cyc < 17) step();
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (an1 !== 8'hFF) begin fails++; $display("FAIL arst_an: got %h expected ff", an1); end
        tests++; if (num1 !== 3'd0) begin fails++; $display("FAIL arst_num: got %0d expected 0", num1); end
        tests++; if (dig1 !== 32'h0) begin fails++; $display("FAIL arst_dig: got %h expected 0", dig1); end
        tests++; if (bus1.wr_ready !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b expected 1", bus1.wr_ready); end
        #2;
        rst_n = 1'b1;
        step();
        tests++; if (an1 !== 8'hFE) begin fails++; $display("FAIL restart_an: got %h expected fe", an1); end
        tests++; if (num1 !== 3'd0) begin fails++; $display("FAIL restart_num: got %0d expected 0", num1); end
        tests++; if (dig1 !== 32'h0) begin fails++; $display("FAIL restart_dig: got %h expected 0", dig1); end
    endtask

    task automatic test_num_digits_4();
        logic [2:0] e_num;
        logic [7:0] e_an;
        start_scan();
        for (int i = 0; i < 40; i++) begin
            step();
            e_num = 3'((cyc / 4) % 4);
            e_an  = ~(8'b1 << e_num);
            tests++; if (num2 !== e_num) begin fails++; $display("FAIL nd4_num c%0d: got %0d expected %0d", cyc, num2, e_num); end
            tests++; if (an2 !== e_an) begin fails++; $display("FAIL nd4_an c%0d: got %h expected %h", cyc, an2, e_an); end
            tests++; if (fd2 !== (cyc == 16 || cyc == 32)) begin fails++; $display("FAIL nd4_fd c%0d: got %b expected %b", cyc, fd2, cyc == 16 || cyc == 32); end
        end
    endtask

    task automatic test_blank();
        logic [2:0] n;
        logic [7:0] e_an;
        start_scan();
        step();
        bus1.wr_valid = 1'b1; bus1.wr_data = 32'h0000_00A5;
        step();
        bus1.wr_valid = 1'b0;
        while (cyc < 32) step();
        tests++; if (dig1 !== 32'h0000_00A5) begin fails++; $display("FAIL blank_dig: got %h expected 000000a5", dig1); end
        while (cyc < 63) begin
            step();
            n = 3'((cyc / 4) % 8);
`ifdef LEADING_ZERO_BLANK_EN
            e_an = (n <= 3'd1) ? ~(8'b1 << n) : 8'hFF;
`else
            e_an = ~(8'b1 << n);
`endif
            tests++; if (an1 !== e_an) begin fails++; $display("FAIL blank_a5 c%0d: got %h expected %h", cyc, an1, e_an); end
            if (cyc == 33) begin bus1.wr_valid = 1'b1; bus1.wr_data = 32'h0; end
            if (cyc == 34) bus1.wr_valid = 1'b0;
        end
        while (cyc < 95) begin
            step();
            n = 3'((cyc / 4) % 8);
`ifdef LEADING_ZERO_BLANK_EN
            e_an = (n == 3'd0) ? 8'hFE : 8'hFF;
`else
            e_an = ~(8'b1 << n);
`endif
            tests++; if (an1 !== e_an) begin fails++; $display("FAIL blank_zero c%0d: got %h expected %h", cyc, an1, e_an); end
        end
        tests++; if (dig1 !== 32'h0) begin fails++; $display("FAIL blank_dig0: got %h expected 0", dig1); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_back_to_back();
        test_en_drop_reset();
        test_num_digits_4();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
